// File: rtl/mtm_alu_sched_if.sv
// Request/response bus between the two on-chip requesters and the mtm_Alu scheduler.
interface mtm_alu_sched_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0;
    logic [31:0] req_b0;
    logic [31:0] req_a1;
    logic [31:0] req_b1;
    logic [2:0]  req_op0;
    logic [2:0]  req_op1;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_c;
    logic [7:0]  rsp_ctl;
    logic        rsp_err;
    logic        rsp_crc_bad;
    logic        rsp_timeout;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
        input  req_ready, rsp_valid, rsp_c, rsp_ctl, rsp_err, rsp_crc_bad, rsp_timeout
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
        output req_ready, rsp_valid, rsp_c, rsp_ctl, rsp_err, rsp_crc_bad, rsp_timeout
    );
endinterface

// File: rtl/mtm_alu_sched.sv
// Round-robin scheduler sharing one mtm_Alu serial link between two requesters.
// One transaction in flight: accept, serialise command, collect response, report.
module mtm_alu_sched #(
    parameter int TIMEOUT = 256,
    parameter int GAP     = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mtm_alu_sched_if.slave bus,
    output logic           sin,
    input  logic           sout
);
    localparam int FRAME_LEN = 11 + GAP;
    localparam int BW        = $clog2(FRAME_LEN);
    localparam int TW        = $clog2(TIMEOUT);
    localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] LAST_IDLE = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, TX, WAIT, RX, DONE} state_t;

    state_t        state, state_nxt;
    logic          last_served;
    logic          grant;
    logic          accept;
    logic [1:0]    ready;
    logic [1:0]    rsp_valid;
    logic [63:0]   tx_data;
    logic [2:0]    tx_op;
    logic [3:0]    tx_frame;
    logic [BW-1:0] tx_bit;
    logic [3:0]    crc4;
    logic [3:0]    crc4_final;
    logic [7:0]    tx_byte;
    logic [2:0]    tx_idx;
    logic [TW-1:0] idle_cnt;
    logic [3:0]    rx_bit;
    logic [2:0]    rx_frame;
    logic          rx_err_frame;
    logic [31:0]   rx_c;
    logic [7:0]    rx_byte;
    logic [2:0]    crc3;
    logic [31:0]   rsp_c_q;
    logic [7:0]    rsp_ctl_q;
    logic          rsp_err_q;
    logic          rsp_crc_bad_q;
    logic          rsp_timeout_q;

    function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic din);
        logic fb;
        fb = crc[3] ^ din;
        return {crc[2], crc[1], crc[0] ^ fb, fb};
    endfunction

    function automatic logic [2:0] crc3_step(input logic [2:0] crc, input logic din);
        logic fb;
        fb = crc[2] ^ din;
        return {crc[1], crc[0] ^ fb, fb};
    endfunction

    // The running CRC covers the 64 data bits; the trailing {1, OP} bits are folded in here.
    assign crc4_final = crc4_step(crc4_step(crc4_step(crc4_step(crc4, 1'b1),
                                  tx_op[2]), tx_op[1]), tx_op[0]);
    assign tx_byte    = (tx_frame == 4'd8) ? {1'b0, tx_op, crc4_final}
                                           : tx_data[{~tx_frame[2:0], 3'b000} +: 8];
    assign tx_idx     = 3'(9 - int'(tx_bit));

    assign bus.req_ready   = ready;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_c       = rsp_c_q;
    assign bus.rsp_ctl     = rsp_ctl_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_crc_bad = rsp_crc_bad_q;
    assign bus.rsp_timeout = rsp_timeout_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, arbitration, serial line drive and the response pulse.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        accept    = 1'b0;
        ready     = 2'b00;
        rsp_valid = 2'b00;
        sin       = 1'b1;
        case (state)
            IDLE: begin
                if (bus.req_valid == 2'b11) grant = ~last_served;
                else                        grant = bus.req_valid[1];
                if (|bus.req_valid) begin
                    accept    = 1'b1;
                    ready     = grant ? 2'b10 : 2'b01;
                    state_nxt = TX;
                end
            end
            TX: begin
                if (tx_bit == 0)      sin = 1'b0;
                else if (tx_bit == 1) sin = (tx_frame == 4'd8);
                else if (tx_bit <= 9) sin = tx_byte[tx_idx];
                if (tx_frame == 4'd8 && tx_bit == LAST_BIT) state_nxt = WAIT;
            end
            WAIT: begin
                if (!sout)                      state_nxt = RX;
                else if (idle_cnt == LAST_IDLE) state_nxt = DONE;
            end
            RX: begin
                if (rx_bit == 4'd10) begin
                    if (!sout || rx_err_frame || rx_frame == 3'd4) state_nxt = DONE;
                    else                                            state_nxt = WAIT;
                end
            end
            DONE: begin
                rsp_valid = last_served ? 2'b10 : 2'b01;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the granted request and step through the command frames while transmitting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_served <= 1'b1;
            tx_data     <= '0;
            tx_op       <= '0;
            tx_frame    <= '0;
            tx_bit      <= '0;
            crc4        <= '0;
        end else if (accept) begin
            last_served <= grant;
            tx_data     <= grant ? {bus.req_b1, bus.req_a1} : {bus.req_b0, bus.req_a0};
            tx_op       <= grant ? bus.req_op1 : bus.req_op0;
            tx_frame    <= '0;
            tx_bit      <= '0;
            crc4        <= '0;
        end else if (state == TX) begin
            if (tx_frame != 4'd8 && tx_bit >= 2 && tx_bit <= 9)
                crc4 <= crc4_step(crc4, tx_byte[tx_idx]);
            if (tx_bit == LAST_BIT) begin
                tx_bit   <= '0;
                tx_frame <= tx_frame + 4'd1;
            end else begin
                tx_bit <= tx_bit + BW'(1);
            end
        end
    end

    // Deserialise response frames, track idle time and accumulate CRC3 over C and the flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt     <= '0;
            rx_bit       <= 4'd1;
            rx_frame     <= '0;
            rx_err_frame <= 1'b0;
            rx_c         <= '0;
            rx_byte      <= '0;
            crc3         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    idle_cnt     <= '0;
                    rx_bit       <= 4'd1;
                    rx_frame     <= '0;
                    rx_err_frame <= 1'b0;
                    rx_c         <= '0;
                    crc3         <= '0;
                end
                TX: idle_cnt <= '0;
                WAIT: begin
                    rx_bit <= 4'd1;
                    if (sout) idle_cnt <= idle_cnt + TW'(1);
                end
                RX: begin
                    idle_cnt <= '0;
                    rx_bit   <= rx_bit + 4'd1;
                    if (rx_bit == 1 && rx_frame == 0) rx_err_frame <= sout;
                    if (rx_bit >= 2 && rx_bit <= 9) begin
                        rx_byte <= {rx_byte[6:0], sout};
                        if (rx_frame != 3'd4) rx_c <= {rx_c[30:0], sout};
                        if (rx_frame != 3'd4 || rx_bit <= 6) crc3 <= crc3_step(crc3, sout);
                    end
                    if (rx_bit == 4'd10) rx_frame <= rx_frame + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Latch the response outputs on entry to DONE; they hold until the next DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_c_q       <= '0;
            rsp_ctl_q     <= '0;
            rsp_err_q     <= 1'b0;
            rsp_crc_bad_q <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else if (state_nxt == DONE) begin
            if (state == WAIT) begin
                rsp_c_q       <= '0;
                rsp_ctl_q     <= '0;
                rsp_err_q     <= 1'b0;
                rsp_crc_bad_q <= 1'b0;
                rsp_timeout_q <= 1'b1;
            end else if (!sout) begin
                rsp_c_q       <= rx_c;
                rsp_ctl_q     <= rx_byte;
                rsp_err_q     <= 1'b0;
                rsp_crc_bad_q <= 1'b1;
                rsp_timeout_q <= 1'b0;
            end else if (rx_err_frame) begin
                rsp_c_q       <= '0;
                rsp_ctl_q     <= rx_byte;
                rsp_err_q     <= 1'b1;
                rsp_crc_bad_q <= 1'b0;
                rsp_timeout_q <= 1'b0;
            end else begin
                rsp_c_q       <= rx_c;
                rsp_ctl_q     <= rx_byte;
                rsp_err_q     <= 1'b0;
                rsp_crc_bad_q <= (crc3 != rx_byte[2:0]);
                rsp_timeout_q <= 1'b0;
            end
        end
    end
endmodule

// File: doc/mtm_alu_sched.md
# mtm_alu_sched

Round-robin scheduler that shares one mtm_Alu serial link between two parallel requesters. Per transaction it:
- takes a 32-bit operand pair and an opcode from the granted requester;
- serialises the 9-frame command packet onto `sin`, computing CRC4 on the fly;
- deserialises the mtm_Alu response from `sout` and checks its CRC3;
- returns result, flags and status to the originating requester.

It sits between the on-chip request logic and the mtm_Alu core, one transaction in flight at a time.

## Interface
- `TIMEOUT`, 256: max idle cycles allowed before a response frame start, or between response frames.
- `GAP`, 2: idle (`1`) bits inserted between transmitted frames.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid[1:0]` in 2: request present, per requester.
- `req_ready[1:0]` out 2: request accepted this cycle, per requester.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in 32 each: operands A and B for requester 0 and requester 1.
- `req_op0`, `req_op1` in 3: opcode, forwarded unmodified (AND 000, OR 001, ADD 100, SUB 101).
- `sin` out 1: serial line to mtm_Alu.
- `sout` in 1: serial line from mtm_Alu, same clock domain, sampled directly.
- `rsp_valid[1:0]` out 2: one-cycle response pulse to the owning requester. There is no backpressure.
- `rsp_c` out 32: result C.
- `rsp_ctl` out 8: raw response CTL byte.
- `rsp_err` out 1: ALU error frame received (`rsp_ctl[7]`=1).
- `rsp_crc_bad` out 1: local CRC3 mismatch on the response.
- `rsp_timeout` out 1: response timeout.

## Operation
Frame format, 11 bits, one bit per clk:
- start `0`;
- cmd bit (`0` = DATA, `1` = CTL);
- 8 payload bits, MSB first;
- stop `1`.

Command packet:
- data frames in order B[31:24], B[23:16], B[15:8], B[7:0], A[31:24], A[23:16], A[15:8], A[7:0];
- then one CTL frame {0, OP[2:0], CRC4}.
- CRC4: polynomial x^4+x+1, initial value 0, computed over the 68-bit vector {B, A, 1'b1, OP}, MSB first.
- `GAP` idle bits follow every frame.

Arbitration:
- Evaluated only in IDLE.
- If exactly one requester is valid, it is granted.
- If both are valid, the requester not served last is granted.
- After reset, "last served" = 1, so requester 0 wins the first tie.
- `req_ready[i]` is asserted in IDLE, in the same cycle, for the granted i only.
- Operands and opcode are captured on `req_valid[i] && req_ready[i]`.

State machine:
- IDLE → TX on accept.
- TX → WAIT after the last CTL stop bit and its gap.
- WAIT → RX on `sout`=0 (start bit); the sample in the following cycle is the cmd bit.
- RX, cmd bit of the first response frame:
  - `1`: error frame. That frame is the whole response → DONE with `rsp_err`=1 and `rsp_c`=0.
  - `0`: collect 4 DATA frames (C[31:24] first) then 1 CTL frame {0, CARRY, OVF, ZERO, NEG, CRC3}.
- RX: between response frames, return to a WAIT-like idle-bit watch, with the same timeout.
- RX → DONE after the final stop bit.
- DONE → IDLE after one cycle. `rsp_valid[owner]` pulses during the DONE cycle.
- WAIT or inter-frame idle: if `TIMEOUT` consecutive idle cycles elapse → DONE with `rsp_timeout`=1, `rsp_c`=0, `rsp_ctl`=0.

Response checks:
- CRC3: polynomial x^3+x+1, initial value 0, over the 37-bit vector {C, 1'b0, CARRY, OVF, ZERO, NEG}. A mismatch sets `rsp_crc_bad`.
- CRC3 is not checked on error frames.
- A stop bit sampled as `0` is treated as a framing error: `rsp_crc_bad`=1 → DONE immediately.

## Timing
Reset values:
- `sin`=1, `req_ready`=0, `rsp_valid`=0, `rsp_c`=0, `rsp_ctl`=0, all flags 0;
- state IDLE, last served = 1.

Asserting `rst_n` low at any point, including mid-TX or mid-RX, immediately forces the reset state; the aborted transaction produces no response.

Transmit latency:
- The first start bit drives `sin` in the cycle after accept.
- TX lasts 9 × (11 + `GAP`) cycles: 117 cycles at default `GAP`.

Response outputs:
- `rsp_c`, `rsp_ctl` and all flags are valid in the `rsp_valid` cycle and held until the next DONE.

Back-to-back requests:
- The earliest next accept is the cycle after DONE.
- A request whose `req_valid` drops before it is granted is simply skipped.

## Test plan
- **Single ADD.** Requester 0 sends A=0xFFFFFFFF, B=0x00000001, op 100. Check `sin` carries CTL payload {0,100,CRC4}. Bench model returns C=0 with flags CARRY=1, ZERO=1. Expect `rsp_valid[0]` with `rsp_c`=0, `rsp_ctl[6:3]`=1010, `rsp_crc_bad`=0.
- **Contention.** Both requesters valid in the first cycle after reset (AND of 0xFFFFFFFF/0 and OR of 0/0). Expect requester 0 served first, then requester 1. Each result appears on its own `rsp_valid` bit only.
- **Error frame.** Bench model answers a single CTL frame 0xA5. Expect `rsp_err`=1, `rsp_ctl`=0xA5, `rsp_c`=0, and a return to IDLE.
- **Timeout.** Hold `sout`=1 after TX. Expect `rsp_valid` with `rsp_timeout`=1 exactly `TIMEOUT` cycles after WAIT is entered.
- **Corrupt response.** Flip one bit of the response CRC3. Expect `rsp_crc_bad`=1 while `rsp_c` still holds the received value.
- **Reset mid-TX.** Pulse `rst_n` low at frame 4 of TX. Expect `sin`=1 immediately, no `rsp_valid`, and the next request served normally.
